// File: rtl/aes_pkg.sv
// Shared AES definitions: round count, key-schedule round constants,
// key-expansion FSM encoding and GF(2^8) multiply used by the S-box.
package aes_pkg;

  localparam int AES_NR = 10;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_EXPAND = 2'd1,
    ST_DONE   = 2'd2
  } kx_state_e;

  localparam logic [7:0] RCON [10] = '{
    8'h01, 8'h02, 8'h04, 8'h08, 8'h10,
    8'h20, 8'h40, 8'h80, 8'h1b, 8'h36
  };

  function automatic logic [7:0] gf_mul(
    input logic [7:0] a,
    input logic [7:0] b
  );
    logic [7:0] p;
    logic [7:0] x;
    p = 8'h00;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction

endpackage

// File: rtl/aes_sbox.sv
// Combinational AES S-box: GF(2^8) inverse (x^254) then affine map.
// Shared between the key schedule and the sub-bytes stage.
module aes_sbox
  import aes_pkg::*;
(
  input  logic [7:0] in_i,
  output logic [7:0] out_o
);

  logic [7:0] x2, x3, x6, x12, x15;
  logic [7:0] x30, x60, x120, x240;
  logic [7:0] x252, inv;

  // Addition chain to x^254, which is the inverse (and maps 0 to 0)
  assign x2   = gf_mul(in_i, in_i);
  assign x3   = gf_mul(x2, in_i);
  assign x6   = gf_mul(x3, x3);
  assign x12  = gf_mul(x6, x6);
  assign x15  = gf_mul(x12, x3);
  assign x30  = gf_mul(x15, x15);
  assign x60  = gf_mul(x30, x30);
  assign x120 = gf_mul(x60, x60);
  assign x240 = gf_mul(x120, x120);
  assign x252 = gf_mul(x240, x12);
  assign inv  = gf_mul(x252, x2);

  assign out_o = inv
               ^ {inv[6:0], inv[7]}
               ^ {inv[5:0], inv[7:6]}
               ^ {inv[4:0], inv[7:5]}
               ^ {inv[3:0], inv[7:4]}
               ^ 8'h63;

endmodule

// File: rtl/aes_key_expansion.sv
// AES-128 key schedule, one round key per cycle into an 11-entry store.
// Optional AES_KEYEXP_ZEROIZE_EN adds a zeroize input that wipes the store.
module aes_key_expansion
  import aes_pkg::*;
#(
  parameter int NR = AES_NR
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [127:0] key_in,
  input  logic         key_load,
`ifdef AES_KEYEXP_ZEROIZE_EN
  input  logic         zeroize,
`endif
  input  logic [3:0]   round_idx,
  output logic [127:0] round_key,
  output logic         busy,
  output logic         key_ready
);

  localparam logic [3:0] LAST = 4'(NR);

  kx_state_e    state_q, state_d;
  logic [3:0]   cnt_q;
  logic [127:0] store_q [NR+1];

  logic         zero_req;
  logic         load_go;
  logic [3:0]   prev_idx;
  logic [127:0] prev_key;
  logic [31:0]  w0, w1, w2, w3;
  logic [31:0]  rot, sub, tmp;
  logic [31:0]  n0, n1, n2, n3;
  logic [127:0] next_key;

`ifdef AES_KEYEXP_ZEROIZE_EN
  assign zero_req = zeroize;
`else
  assign zero_req = 1'b0;
`endif

  assign load_go = key_load && (state_q != ST_EXPAND);

  assign prev_idx = (cnt_q == 4'd0) ? 4'd0 : cnt_q - 4'd1;
  assign prev_key = store_q[prev_idx];
  assign {w0, w1, w2, w3} = prev_key;

  assign rot = {w3[23:0], w3[31:24]};

  for (genvar b = 0; b < 4; b++) begin : g_sbox
    aes_sbox u_sbox (
      .in_i  (rot[8*b +: 8]),
      .out_o (sub[8*b +: 8])
    );
  end

  assign tmp = sub ^ {RCON[prev_idx], 24'h0};
  assign n0  = w0 ^ tmp;
  assign n1  = w1 ^ n0;
  assign n2  = w2 ^ n1;
  assign n3  = w3 ^ n2;
  assign next_key = {n0, n1, n2, n3};

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE,
      ST_DONE:   if (key_load) state_d = ST_EXPAND;
      ST_EXPAND: if (cnt_q == LAST) state_d = ST_DONE;
      default:   state_d = ST_IDLE;
    endcase
    if (zero_req) state_d = ST_IDLE;
  end

  always_comb begin
    busy      = (state_q == ST_EXPAND);
    key_ready = (state_q == ST_DONE);
    round_key = 128'h0;
    if (key_ready && (round_idx <= LAST))
      round_key = store_q[round_idx];
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt_q <= 4'd0;
      for (int i = 0; i <= NR; i++) store_q[i] <= 128'h0;
    end else if (zero_req) begin
      cnt_q <= 4'd0;
      for (int i = 0; i <= NR; i++) store_q[i] <= 128'h0;
    end else if (load_go) begin
      store_q[0] <= key_in;
      cnt_q      <= 4'd1;
    end else if (state_q == ST_EXPAND) begin
      store_q[cnt_q] <= next_key;
      if (cnt_q != LAST) cnt_q <= cnt_q + 4'd1;
    end
  end

endmodule

// File: tb/tb_aes_key_expansion.sv
// Directed bench for aes_key_expansion using FIPS-197 key schedule vectors.
// Build with AES_KEYEXP_ZEROIZE_EN to also exercise zeroize.
module tb_aes_key_expansion;

  logic         clk;
  logic         reset;
  logic [127:0] key_in;
  logic         key_load;
  logic [3:0]   round_idx;
  logic [127:0] round_key;
  logic         busy;
  logic         key_ready;
`ifdef AES_KEYEXP_ZEROIZE_EN
  logic         zeroize;
`endif

  int errors = 0;
  int checks = 0;

  localparam logic [127:0] K_FIPS = 128'h2b7e1516_28aed2a6_abf71588_09cf4f3c;
  localparam logic [127:0] K_ZERO = 128'h0;

  aes_key_expansion dut (
    .clk       (clk),
    .reset     (reset),
    .key_in    (key_in),
    .key_load  (key_load),
`ifdef AES_KEYEXP_ZEROIZE_EN
    .zeroize   (zeroize),
`endif
    .round_idx (round_idx),
    .round_key (round_key),
    .busy      (busy),
    .key_ready (key_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic do_load(input logic [127:0] k);
    @(negedge clk);
    key_in   = k;
    key_load = 1'b1;
    @(negedge clk);
    key_load = 1'b0;
  endtask

  task automatic test_reset;
    reset = 1'b0;
    #1;
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL reset_busy got=%b exp=0", busy);
    end
    checks++;
    if (key_ready !== 1'b0) begin
      errors++;
      $display("FAIL reset_ready got=%b exp=0", key_ready);
    end
    for (int i = 0; i < 16; i += 5) begin
      round_idx = 4'(i);
      #1;
      checks++;
      if (round_key !== 128'h0) begin
        errors++;
        $display("FAIL reset_rk idx=%0d got=%h exp=0", i, round_key);
      end
    end
    @(negedge clk);
    reset = 1'b1;
  endtask

  task automatic test_vectors;
    logic [3:0]   idx [6];
    logic [127:0] exp [6];
    idx = '{4'd0, 4'd1, 4'd2, 4'd5, 4'd9, 4'd10};
    exp = '{K_FIPS,
            128'ha0fafe17_88542cb1_23a33939_2a6c7605,
            128'hf2c295f2_7a96b943_5935807a_7359f67f,
            128'hd4d1c6f8_7c839d87_caf2b8bc_11f915bc,
            128'hac7766f3_19fadc21_28d12941_575c006e,
            128'hd014f9a8_c9ee2589_e13f0cc8_b6630ca6};
    do_load(K_FIPS);
    repeat (10) @(negedge clk);
    checks++;
    if (key_ready !== 1'b1) begin
      errors++;
      $display("FAIL vec_ready got=%b exp=1", key_ready);
    end
    for (int i = 0; i < 6; i++) begin
      round_idx = idx[i];
      #1;
      checks++;
      if (round_key !== exp[i]) begin
        errors++;
        $display("FAIL vec_rk idx=%0d got=%h exp=%h", idx[i], round_key, exp[i]);
      end
    end
  endtask

  task automatic test_latency;
    round_idx = 4'd0;
    do_load(K_FIPS);
    for (int k = 0; k <= 10; k++) begin
      if (k > 0) @(negedge clk);
      checks++;
      if (busy !== (k < 10)) begin
        errors++;
        $display("FAIL lat_busy k=%0d got=%b exp=%b", k, busy, k < 10);
      end
      checks++;
      if (key_ready !== (k == 10)) begin
        errors++;
        $display("FAIL lat_ready k=%0d got=%b exp=%b", k, key_ready, k == 10);
      end
      if (k == 3) begin
        checks++;
        if (round_key !== 128'h0) begin
          errors++;
          $display("FAIL lat_rk_gated got=%h exp=0", round_key);
        end
      end
    end
  endtask

  task automatic test_range;
    for (int i = 11; i < 16; i++) begin
      round_idx = 4'(i);
      #1;
      checks++;
      if (round_key !== 128'h0) begin
        errors++;
        $display("FAIL range_rk idx=%0d got=%h exp=0", i, round_key);
      end
    end
  endtask

  task automatic test_back_to_back;
    do_load(K_FIPS);
    repeat (3) @(negedge clk);
    key_in   = K_ZERO;
    key_load = 1'b1;
    @(negedge clk);
    key_load = 1'b0;
    repeat (6) @(negedge clk);
    checks++;
    if (key_ready !== 1'b1) begin
      errors++;
      $display("FAIL b2b_ready got=%b exp=1", key_ready);
    end
    round_idx = 4'd1;
    #1;
    checks++;
    if (round_key !== 128'ha0fafe17_88542cb1_23a33939_2a6c7605) begin
      errors++;
      $display("FAIL b2b_rk1 got=%h", round_key);
    end
    round_idx = 4'd10;
    #1;
    checks++;
    if (round_key !== 128'hd014f9a8_c9ee2589_e13f0cc8_b6630ca6) begin
      errors++;
      $display("FAIL b2b_rk10 got=%h", round_key);
    end
  endtask

  task automatic test_reset_abort;
    do_load(K_FIPS);
    repeat (4) @(negedge clk);
    reset = 1'b0;
    #1;
    checks++;
    if (key_ready !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL abort_flags got ready=%b busy=%b exp=0/0", key_ready, busy);
    end
    for (int i = 0; i < 16; i++) begin
      round_idx = 4'(i);
      #1;
      checks++;
      if (round_key !== 128'h0) begin
        errors++;
        $display("FAIL abort_rk idx=%0d got=%h exp=0", i, round_key);
      end
    end
    @(negedge clk);
    reset = 1'b1;
    repeat (2) @(negedge clk);
    checks++;
    if (key_ready !== 1'b0) begin
      errors++;
      $display("FAIL abort_ready_post got=%b exp=0", key_ready);
    end
    do_load(K_ZERO);
    repeat (10) @(negedge clk);
    round_idx = 4'd10;
    #1;
    checks++;
    if (round_key !== 128'hb4ef5bcb_3e92e211_23e951cf_6f8f188e) begin
      errors++;
      $display("FAIL zero_rk10 got=%h", round_key);
    end
    round_idx = 4'd1;
    #1;
    checks++;
    if (round_key !== 128'h62636363_62636363_62636363_62636363) begin
      errors++;
      $display("FAIL zero_rk1 got=%h", round_key);
    end
  endtask

`ifdef AES_KEYEXP_ZEROIZE_EN
  task automatic test_zeroize;
    @(negedge clk);
    zeroize  = 1'b1;
    key_load = 1'b1;
    key_in   = K_FIPS;
    @(negedge clk);
    zeroize  = 1'b0;
    key_load = 1'b0;
    checks++;
    if (key_ready !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL zz_flags got ready=%b busy=%b exp=0/0", key_ready, busy);
    end
    @(negedge clk);
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL zz_idle got busy=%b exp=0", busy);
    end
    do_load(K_FIPS);
    repeat (2) @(negedge clk);
    reset = 1'b0;
    round_idx = 4'd0;
    #1;
    checks++;
    if (round_key !== 128'h0 || key_ready !== 1'b0) begin
      errors++;
      $display("FAIL zz_store got=%h ready=%b exp=0", round_key, key_ready);
    end
    @(negedge clk);
    reset = 1'b1;
  endtask
`endif

  initial begin
    reset     = 1'b0;
    key_in    = 128'h0;
    key_load  = 1'b0;
    round_idx = 4'd0;
`ifdef AES_KEYEXP_ZEROIZE_EN
    zeroize   = 1'b0;
`endif
    test_reset;
    test_vectors;
    test_latency;
    test_range;
    test_back_to_back;
    test_reset_abort;
`ifdef AES_KEYEXP_ZEROIZE_EN
    test_zeroize;
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/aes_key_expansion.md
AES_KEY_EXPANSION -- requirements
Module: aes_key_expansion

Interface
REQ-001 SHALL have parameter NR, default 10, meaning number of AES rounds; only 10 (AES-128) is legal.
REQ-002 SHALL have port clk  input  1  system clock, all state on rising edge.
REQ-003 SHALL have port reset  input  1  asynchronous, active-low reset.
REQ-004 SHALL have port key_in  input  128  cipher key; word w0 = key_in[127:96], w3 = key_in[31:0].
REQ-005 SHALL have port key_load  input  1  single-cycle start strobe; key_in is sampled when it is high.
REQ-006 SHALL have port round_idx  input  4  round-key select, 0..10, driven by the downstream add_round_key/round controller.
REQ-007 SHALL have port round_key  output  128  selected round key, feeds the add-round-key stage.
REQ-008 SHALL have port busy  output  1  high while expansion is in progress.
REQ-009 SHALL have port key_ready  output  1  high while all 11 round keys are valid.

Function
REQ-010 SHALL implement the FSM states IDLE, EXPAND and DONE.
REQ-011 SHALL, on key_load in IDLE or DONE: write key_in to store[0], set the counter to 1, enter EXPAND, deassert key_ready the next cycle and assert busy.
REQ-012 SHALL, in EXPAND, write store[i] = FIPS-197 expansion of store[i-1] with rcon[i] (RotWord, SubWord, Rcon XOR, word chaining), one round key per cycle.
REQ-013 SHALL write store[1..10] on edges T+1..T+10 when key_load is sampled at edge T; key_ready is high and busy low after edge T+10.
REQ-014 SHALL move from EXPAND to DONE when the counter equals 10; DONE holds until the next key_load or reset.
REQ-015 SHALL ignore key_load while in EXPAND; the expansion in progress completes unchanged.
REQ-016 SHALL drive round_key = store[round_idx] combinationally when key_ready is high and round_idx <= 10, and 128'h0 otherwise.
REQ-017 SHALL set key_ready=1 and busy=1 never simultaneously.
REQ-018 SHALL compute SubWord with four parallel S-box instances; there is no multi-cycle S-box.

Reset
REQ-019 SHALL, while reset is low: enter IDLE, clear counter and all 11 store entries, and drive busy=0, key_ready=0, round_key=0.
REQ-020 SHALL abort an in-progress expansion when reset is asserted mid-EXPAND; after release, key_ready stays 0 until a fresh key_load completes.

Configuration
REQ-021 SHALL, with macro AES_KEYEXP_ZEROIZE_EN defined, add input port zeroize (1 bit), which clears all store entries, returns to IDLE and drops key_ready/busy on the next edge, with priority over key_load.
REQ-022 SHALL, without AES_KEYEXP_ZEROIZE_EN, omit the zeroize port; store contents persist until overwritten by a new key_load.

Structure
REQ-023 SHALL take NR, the rcon table (01,02,04,08,10,20,40,80,1b,36) and the FSM state encoding from the shared package aes_pkg.
REQ-024 SHALL instantiate sub-module aes_sbox (8-bit combinational S-box) four times; aes_sbox is shared with the sub-bytes stage.

Verification
REQ-025 SHALL verify: key_load with key 2b7e1516_28aed2a6_abf71588_09cf4f3c -> round_idx=1 gives a0fafe17_88542cb1_23a33939_2a6c7605, round_idx=10 gives d014f9a8_c9ee2589_e13f0cc8_b6630ca6, round_idx=0 returns the key.
REQ-026 SHALL verify latency: key_load sampled at edge T -> busy high T+1..T+10, key_ready rises exactly after edge T+10.
REQ-027 SHALL verify: second key_load (key all zeros) at T+4 -> ignored, and results equal REQ-025 values.
REQ-028 SHALL verify: reset low at T+5 -> key_ready=0, round_key=0 for all idx; a new key_load of 000..0 then yields round 10 key b4ef5bcb_3e92e211_23e951cf_6f8f188e.
REQ-029 SHALL verify: round_idx=11..15 with key_ready=1 -> round_key=0; any idx with key_ready=0 -> round_key=0.
REQ-030 SHALL verify, with AES_KEYEXP_ZEROIZE_EN: zeroize and key_load asserted in the same cycle in DONE -> IDLE, key_ready=0, and the store reads 0 once a later load is aborted by reset.
